iorq_cycle_fsm: RTL and testbench
=================================

# iorq_cycle_fsm

Parametrised Z8S180 I/O-cycle tracker for the nouveau-vdp99 bus interface, replacing the single-port write-only strobe FSM. Samples the CPU bus on falling `phi` edges, decodes a contiguous block of `NUM_PORTS` I/O addresses, and emits a one-`phi`-period write or read tick to the addressed port after a programmable number of qualifying edges. Interrupt-acknowledge cycles are excluded, illegal rd+wr overlap is flagged, and an optional wait-state hook stalls the tick while the VDP core is busy. Bus inputs meet FPGA setup/hold with the CPU in IOC=1 mode; no metastability synchronisers are included.

## Interface
- `NUM_PORTS`, 2: number of consecutive I/O ports decoded, 1..8.
- `ADDR_W`, 8: I/O address bits compared.
- `BASE_ADDR`, 8'h98: address of port 0; port k = BASE_ADDR+k.
- `WR_DELAY`, 1: qualifying falling edges before the write tick, 1..7.
- `RD_DELAY`, 1: qualifying falling edges before the read tick, 1..7.
- `phi  in  1`: CPU phi clock; all state updates on its falling edge.
- `reset  in  1`: synchronous, active-high; sampled on falling `phi`.
- `iorq  in  1`: positive-logic IORQ.
- `m1  in  1`: positive-logic M1; `iorq && m1` is INTACK and is never decoded.
- `wr  in  1`: positive-logic WR.
- `rd  in  1`: positive-logic RD.
- `addr  in  ADDR_W`: CPU address, low bits.
- `wr_tick  out  NUM_PORTS`: one-hot write strobe, high for one phi period.
- `rd_tick  out  NUM_PORTS`: one-hot read strobe, high for one phi period.
- `port_idx  out  3`: latched index of the active port; 0 when idle.
- `cycle_err  out  1`: sticky; set when `iorq && rd && wr` is sampled.
- `busy  in  1`, `wait_n  out  1`: present only with `IORQ_CYCLE_WAIT_EN`.

## Operation
- Qualify: `q = iorq && !m1 && (rd ^ wr) && addr in [BASE_ADDR, BASE_ADDR+NUM_PORTS-1]`.
- States: IDLE, COUNT, FIRE, HOLD. The 3-bit counter `cnt` and latches `dir` (1 = write) and `idx` update only on falling `phi`.
- IDLE: on `q`, latch `dir=wr`, `idx=addr-BASE_ADDR`, and set `cnt=1`. Go to FIRE if the selected DELAY==1, otherwise go to COUNT.
- COUNT: while `iorq && (dir ? wr : rd)`, increment `cnt`; go to FIRE when `cnt+1 == DELAY`. If the qualifier drops, go to IDLE with no tick (aborted cycle).
- FIRE: assert `wr_tick[idx]` or `rd_tick[idx]` for exactly this state. On the next edge go to HOLD if the qualifier is still true, otherwise go to IDLE.
- HOLD: remain while the qualifier is true; return to IDLE when it drops. Exactly one tick per IORQ assertion.
- `addr` is ignored after IDLE; a change of direction mid-cycle drops the qualifier, so the FSM returns to IDLE or aborts.
- `cycle_err` is set whenever `iorq && rd && wr` is sampled in any state, and is cleared only by `reset`. That cycle is not decoded.
- `port_idx = idx` outside IDLE, and 0 in IDLE.

## Timing
- Reset values: state IDLE, `cnt=0`, `wr_tick=0`, `rd_tick=0`, `port_idx=0`, `cycle_err=0`, `wait_n=1`.
- Ticks are Moore outputs of registered state: they change only after a falling `phi` and are glitch-free.
- With WR_DELAY=D, `wr_tick` is high from the D-th consecutive qualifying falling edge to the (D+1)-th. D=1 reproduces the legacy single-port timing.
- Reset asserted mid-cycle forces IDLE on that edge with no tick. A still-asserted `iorq` after reset release is re-decoded as a fresh cycle.
- Back-to-back cycles need at least one sampled edge with `iorq` low between them; otherwise HOLD absorbs the second cycle.

## Configuration
- `IORQ_CYCLE_WAIT_EN` defined:
  - The `busy` and `wait_n` ports exist.
  - In the state that would enter FIRE, a sampled `busy=1` keeps the FSM there (counter saturated) and drives `wait_n=0`, combinationally from state and `busy`.
  - FIRE is entered on the first edge with `busy=0`.
  - If the qualifier drops while stalled, go to IDLE with no tick.
- `IORQ_CYCLE_WAIT_EN` undefined: the ports are absent and there is no stall; the tick fires on the DELAY edge unconditionally.

## Structure
- Package `iorq_pkg`: state encoding localparams (IDLE=0, COUNT=1, FIRE=2, HOLD=3), `IORQ_IDX_W=3`, `IORQ_CNT_W=3`.
- Sub-module `iorq_port_decode`: range compare of `addr` against BASE_ADDR and NUM_PORTS → `hit` and `idx`, purely combinational.
- Parameter checks at elaboration: DELAY values in 1..7, NUM_PORTS in 1..8, BASE_ADDR+NUM_PORTS-1 < 2^ADDR_W.

## Test plan
- Defaults; write 8'h99 with iorq+wr held 3 edges → `wr_tick=2'b10` for exactly one period after edge 1; `port_idx=1`; no `rd_tick`.
- RD_DELAY=3; read 8'h98 held 5 edges → `rd_tick=2'b01` between edges 3 and 4; deassert after edge 2 instead → no tick, FSM back in IDLE.
- INTACK (iorq+m1+rd at 8'h98) and write to 8'h9A → no ticks, `port_idx=0`.
- iorq+rd+wr sampled → `cycle_err=1` and no tick; holds through later legal cycles until `reset`.
- Reset asserted on the edge where FIRE would be entered → no tick; all outputs take reset values.
- `IORQ_CYCLE_WAIT_EN`, WR_DELAY=1, `busy` high for 2 edges → `wait_n=0` for 2 periods; `wr_tick` fires on the edge where `busy` is first seen low.

Source files
------------

// File: rtl/iorq_cycle_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : iorq_pkg
//  Purpose   : Shared encodings and widths for the Z8S180 I/O-cycle tracker.
//              State encoding, index/counter widths and the state enum used
//              by iorq_cycle_fsm and its interface.
//  Revision  : 1.0  initial release
// ============================================================================
package iorq_pkg;

   localparam int IORQ_IDX_W = 3;
   localparam int IORQ_CNT_W = 3;

   localparam logic [1:0] IORQ_ST_IDLE  = 2'd0;
   localparam logic [1:0] IORQ_ST_COUNT = 2'd1;
   localparam logic [1:0] IORQ_ST_FIRE  = 2'd2;
   localparam logic [1:0] IORQ_ST_HOLD  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = IORQ_ST_IDLE,
      ST_COUNT = IORQ_ST_COUNT,
      ST_FIRE  = IORQ_ST_FIRE,
      ST_HOLD  = IORQ_ST_HOLD
   } iorq_state_e;

endpackage : iorq_pkg
`default_nettype wire

// File: rtl/iorq_cycle_fsm_if.sv
`default_nettype none
// ============================================================================
//  Interface : iorq_cycle_fsm_if
//  Purpose   : CPU bus inputs and port strobe outputs of the I/O-cycle
//              tracker. busy/wait_n exist only when IORQ_CYCLE_WAIT_EN is
//              defined.
//  Signals   : iorq, m1, wr, rd  - positive-logic CPU bus controls
//              addr              - low CPU address bits
//              wr_tick, rd_tick  - one-hot per-port strobes
//              port_idx          - index of the active port (0 when idle)
//              cycle_err         - sticky illegal rd+wr flag
//              busy, wait_n      - optional wait-state hook
//  Modports  : master (CPU/bus side), slave (tracker side)
//  Revision  : 1.0  initial release
// ============================================================================
interface iorq_cycle_fsm_if #(
   parameter int ADDR_W    = 8,
   parameter int NUM_PORTS = 2
);
   import iorq_pkg::*;

   logic                   iorq;
   logic                   m1;
   logic                   wr;
   logic                   rd;
   logic [ADDR_W-1:0]      addr;
   logic [NUM_PORTS-1:0]   wr_tick;
   logic [NUM_PORTS-1:0]   rd_tick;
   logic [IORQ_IDX_W-1:0]  port_idx;
   logic                   cycle_err;
`ifdef IORQ_CYCLE_WAIT_EN
   logic                   busy;
   logic                   wait_n;

   modport master (
      output iorq, m1, wr, rd, addr, busy,
      input  wr_tick, rd_tick, port_idx, cycle_err, wait_n
   );
   modport slave (
      input  iorq, m1, wr, rd, addr, busy,
      output wr_tick, rd_tick, port_idx, cycle_err, wait_n
   );
`else
   modport master (
      output iorq, m1, wr, rd, addr,
      input  wr_tick, rd_tick, port_idx, cycle_err
   );
   modport slave (
      input  iorq, m1, wr, rd, addr,
      output wr_tick, rd_tick, port_idx, cycle_err
   );
`endif

endinterface : iorq_cycle_fsm_if
`default_nettype wire

// File: rtl/iorq_cycle_fsm_port_decode.sv
`default_nettype none
// ============================================================================
//  Module    : iorq_port_decode
//  Purpose   : Combinational range decode of the I/O address against a block
//              of NUM_PORTS consecutive ports starting at BASE_ADDR.
//  Ports     : i_addr - CPU address
//              o_hit  - address lies inside the decoded block
//              o_idx  - offset of the address within the block
//  Revision  : 1.0  initial release
// ============================================================================
module iorq_port_decode
   import iorq_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 8'h98,
   parameter int NUM_PORTS = 2
) (
   input  wire logic [ADDR_W-1:0]     i_addr,
   output      logic                  o_hit,
   output      logic [IORQ_IDX_W-1:0] o_idx
);

   localparam logic [ADDR_W-1:0]   c_base  = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W+3:0]   c_count = (ADDR_W+4)'(NUM_PORTS);

   logic [ADDR_W-1:0] w_off;

   assign w_off = i_addr - c_base;
   // Widened compare so NUM_PORTS never truncates for narrow ADDR_W.
   assign o_hit = (i_addr >= c_base) && ({4'b0000, w_off} < c_count);
   assign o_idx = IORQ_IDX_W'(w_off);

endmodule : iorq_port_decode
`default_nettype wire

// File: rtl/iorq_cycle_fsm.sv
`default_nettype none
// ============================================================================
//  Module    : iorq_cycle_fsm
//  Purpose   : Z8S180 I/O-cycle tracker. Samples the CPU bus on falling phi,
//              decodes NUM_PORTS consecutive ports from BASE_ADDR and emits a
//              one-phi-period write/read tick after WR_DELAY/RD_DELAY
//              qualifying edges. INTACK is ignored, rd+wr overlap is flagged.
//  Ports     : phi   - CPU clock, all state changes on its falling edge
//              reset - synchronous active-high reset
//              bus   - iorq_cycle_fsm_if.slave (bus inputs, tick outputs)
//  Macro     : IORQ_CYCLE_WAIT_EN - adds busy/wait_n stall before the tick
//  Revision  : 1.0  initial release
// ============================================================================
module iorq_cycle_fsm
   import iorq_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 8'h98,
   parameter int WR_DELAY  = 1,
   parameter int RD_DELAY  = 1
) (
   input  wire logic    phi,
   input  wire logic    reset,
   iorq_cycle_fsm_if.slave bus
);

   // ---------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ---------------------------------------------------------------------
   if (WR_DELAY < 1 || WR_DELAY > 7) begin : g_chk_wr_delay
      $error("iorq_cycle_fsm: WR_DELAY must be 1..7");
   end
   if (RD_DELAY < 1 || RD_DELAY > 7) begin : g_chk_rd_delay
      $error("iorq_cycle_fsm: RD_DELAY must be 1..7");
   end
   if (NUM_PORTS < 1 || NUM_PORTS > 8) begin : g_chk_num_ports
      $error("iorq_cycle_fsm: NUM_PORTS must be 1..8");
   end
   if ((longint'(BASE_ADDR) + longint'(NUM_PORTS) - 1) >= (longint'(1) << ADDR_W))
   begin : g_chk_addr_range
      $error("iorq_cycle_fsm: port block exceeds address space");
   end

   localparam logic [IORQ_CNT_W-1:0] c_wr_dly = IORQ_CNT_W'(WR_DELAY);
   localparam logic [IORQ_CNT_W-1:0] c_rd_dly = IORQ_CNT_W'(RD_DELAY);

   iorq_state_e             r_state;
   logic [IORQ_CNT_W-1:0]   r_cnt;
   logic                    r_dir;
   logic [IORQ_IDX_W-1:0]   r_idx;
   logic [IORQ_IDX_W-1:0]   r_port_idx;
   logic [NUM_PORTS-1:0]    r_wr_tick;
   logic [NUM_PORTS-1:0]    r_rd_tick;
   logic                    r_cycle_err;

   logic                    w_hit;
   logic [IORQ_IDX_W-1:0]   w_dec_idx;
   logic                    w_err;
   logic                    w_q;
   logic                    w_hold;
   logic [IORQ_CNT_W-1:0]   w_new_dly;
   logic [IORQ_CNT_W-1:0]   w_cur_dly;
   logic [IORQ_CNT_W:0]     w_cnt_inc;
   logic                    w_cnt_due;
   logic                    w_busy;
   logic [NUM_PORTS-1:0]    w_oh_new;
   logic [NUM_PORTS-1:0]    w_oh_cur;

   iorq_port_decode #(
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (BASE_ADDR),
      .NUM_PORTS (NUM_PORTS)
   ) u_decode (
      .i_addr (bus.addr),
      .o_hit  (w_hit),
      .o_idx  (w_dec_idx)
   );

   assign w_err = bus.iorq && bus.rd && bus.wr;
   assign w_q   = bus.iorq && !bus.m1 && (bus.rd ^ bus.wr) && w_hit;
   // After IDLE the address is ignored; only the latched direction must hold.
   assign w_hold = bus.iorq && !bus.m1 &&
                   (r_dir ? (bus.wr && !bus.rd) : (bus.rd && !bus.wr));

   assign w_new_dly = bus.wr ? c_wr_dly : c_rd_dly;
   assign w_cur_dly = r_dir  ? c_wr_dly : c_rd_dly;
   assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;
   // ">=" also covers a counter parked at DELAY while stalled on busy.
   assign w_cnt_due = w_cnt_inc >= {1'b0, w_cur_dly};

   assign w_oh_new = NUM_PORTS'(1) << w_dec_idx;
   assign w_oh_cur = NUM_PORTS'(1) << r_idx;

`ifdef IORQ_CYCLE_WAIT_EN
   assign w_busy = bus.busy;
   // Low exactly when the FSM would enter FIRE on this edge but busy holds it.
   assign bus.wait_n = !(bus.busy &&
                         (((r_state == ST_IDLE) && w_q && (w_new_dly == 3'd1)) ||
                          ((r_state == ST_COUNT) && w_hold && w_cnt_due)));
`else
   assign w_busy = 1'b0;
`endif

   always_ff @(negedge phi) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_dir       <= 1'b0;
         r_idx       <= '0;
         r_port_idx  <= '0;
         r_wr_tick   <= '0;
         r_rd_tick   <= '0;
         r_cycle_err <= 1'b0;
      end else begin
         if (w_err) begin
            r_cycle_err <= 1'b1;
         end
         r_wr_tick <= '0;
         r_rd_tick <= '0;

         case (r_state)
            ST_IDLE: begin
               if (w_q) begin
                  r_dir      <= bus.wr;
                  r_idx      <= w_dec_idx;
                  r_port_idx <= w_dec_idx;
                  r_cnt      <= 3'd1;
                  if ((w_new_dly == 3'd1) && !w_busy) begin
                     r_state <= ST_FIRE;
                     if (bus.wr) begin
                        r_wr_tick <= w_oh_new;
                     end else begin
                        r_rd_tick <= w_oh_new;
                     end
                  end else begin
                     r_state <= ST_COUNT;
                  end
               end
            end

            ST_COUNT: begin
               if (!w_hold) begin
                  r_state    <= ST_IDLE;
                  r_cnt      <= '0;
                  r_port_idx <= '0;
               end else if (w_cnt_due) begin
                  r_cnt <= w_cur_dly;
                  if (!w_busy) begin
                     r_state <= ST_FIRE;
                     if (r_dir) begin
                        r_wr_tick <= w_oh_cur;
                     end else begin
                        r_rd_tick <= w_oh_cur;
                     end
                  end
               end else begin
                  r_cnt <= w_cnt_inc[IORQ_CNT_W-1:0];
               end
            end

            ST_FIRE: begin
               if (w_hold) begin
                  r_state <= ST_HOLD;
               end else begin
                  r_state    <= ST_IDLE;
                  r_cnt      <= '0;
                  r_port_idx <= '0;
               end
            end

            ST_HOLD: begin
               if (!w_hold) begin
                  r_state    <= ST_IDLE;
                  r_cnt      <= '0;
                  r_port_idx <= '0;
               end
            end

            default: begin
               r_state    <= ST_IDLE;
               r_cnt      <= '0;
               r_port_idx <= '0;
            end
         endcase
      end
   end

   assign bus.wr_tick   = r_wr_tick;
   assign bus.rd_tick   = r_rd_tick;
   assign bus.port_idx  = r_port_idx;
   assign bus.cycle_err = r_cycle_err;

endmodule : iorq_cycle_fsm
`default_nettype wire

// File: tb/tb_iorq_cycle_fsm.sv
`default_nettype none
// ============================================================================
//  Module    : tb_iorq_cycle_fsm
//  Purpose   : Directed self-checking bench for iorq_cycle_fsm
//              (NUM_PORTS=2, BASE_ADDR=8'h98, WR_DELAY=1, RD_DELAY=3).
//              The wait-state section is built only with IORQ_CYCLE_WAIT_EN.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_iorq_cycle_fsm;

   logic phi;
   logic reset;
   int   checks;
   int   failures;

   iorq_cycle_fsm_if #(.ADDR_W(8), .NUM_PORTS(2)) bus ();

   iorq_cycle_fsm #(
      .NUM_PORTS (2),
      .ADDR_W    (8),
      .BASE_ADDR (8'h98),
      .WR_DELAY  (1),
      .RD_DELAY  (3)
   ) dut (
      .phi   (phi),
      .reset (reset),
      .bus   (bus)
   );

   initial phi = 1'b1;
   always #5 phi = ~phi;

   // Advance past one falling phi edge and let registered outputs settle.
   task automatic edge_();
      @(negedge phi);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic bus_set(input logic iorq, input logic m1, input logic wr,
                          input logic rd, input logic [7:0] addr);
      bus.iorq = iorq;
      bus.m1   = m1;
      bus.wr   = wr;
      bus.rd   = rd;
      bus.addr = addr;
   endtask

   task automatic outs(input string tag, input logic [1:0] wt, input logic [1:0] rt,
                       input logic [2:0] pi, input logic ce);
      chk({tag, "_wr_tick"},   32'(bus.wr_tick),   32'(wt));
      chk({tag, "_rd_tick"},   32'(bus.rd_tick),   32'(rt));
      chk({tag, "_port_idx"},  32'(bus.port_idx),  32'(pi));
      chk({tag, "_cycle_err"}, 32'(bus.cycle_err), 32'(ce));
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      bus_set(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
`ifdef IORQ_CYCLE_WAIT_EN
      bus.busy = 1'b0;
`endif
      edge_();
      edge_();
      outs("reset", 2'b00, 2'b00, 3'd0, 1'b0);
      reset = 1'b0;
      edge_();
      outs("idle", 2'b00, 2'b00, 3'd0, 1'b0);

      // Write to port 1, held three edges: one tick after edge 1 only.
      bus_set(1'b1, 1'b0, 1'b1, 1'b0, 8'h99);
      edge_();
      outs("wr99_e1", 2'b10, 2'b00, 3'd1, 1'b0);
      edge_();
      outs("wr99_e2", 2'b00, 2'b00, 3'd1, 1'b0);
      edge_();
      outs("wr99_e3", 2'b00, 2'b00, 3'd1, 1'b0);
      bus_set(1'b0, 1'b0, 1'b0, 1'b0, 8'h99);
      edge_();
      outs("wr99_end", 2'b00, 2'b00, 3'd0, 1'b0);

      // Read port 0 held five edges: tick between edges 3 and 4.
      bus_set(1'b1, 1'b0, 1'b0, 1'b1, 8'h98);
      edge_();
      outs("rd98_e1", 2'b00, 2'b00, 3'd0, 1'b0);
      edge_();
      outs("rd98_e2", 2'b00, 2'b00, 3'd0, 1'b0);
      edge_();
      outs("rd98_e3", 2'b00, 2'b01, 3'd0, 1'b0);
      edge_();
      outs("rd98_e4", 2'b00, 2'b00, 3'd0, 1'b0);
      edge_();
      outs("rd98_e5", 2'b00, 2'b00, 3'd0, 1'b0);
      bus_set(1'b0, 1'b0, 1'b0, 1'b0, 8'h98);
      edge_();

      // Aborted read: deasserted after edge 2, no tick, back to IDLE.
      bus_set(1'b1, 1'b0, 1'b0, 1'b1, 8'h99);
      edge_();
      outs("abort_e1", 2'b00, 2'b00, 3'd1, 1'b0);
      edge_();
      bus_set(1'b0, 1'b0, 1'b0, 1'b0, 8'h99);
      edge_();
      outs("abort_e3", 2'b00, 2'b00, 3'd0, 1'b0);
      edge_();
      outs("abort_e4", 2'b00, 2'b00, 3'd0, 1'b0);

      // INTACK, then writes just outside the block on both sides.
      bus_set(1'b1, 1'b1, 1'b0, 1'b1, 8'h98);
      for (int i = 0; i < 4; i++) begin
         edge_();
         outs("intack", 2'b00, 2'b00, 3'd0, 1'b0);
      end
      bus_set(1'b0, 1'b0, 1'b0, 1'b0, 8'h98);
      edge_();
      bus_set(1'b1, 1'b0, 1'b1, 1'b0, 8'h9A);
      edge_();
      outs("wr9a", 2'b00, 2'b00, 3'd0, 1'b0);
      bus_set(1'b0, 1'b0, 1'b0, 1'b0, 8'h9A);
      edge_();
      bus_set(1'b1, 1'b0, 1'b1, 1'b0, 8'h97);
      edge_();
      outs("wr97", 2'b00, 2'b00, 3'd0, 1'b0);
      bus_set(1'b0, 1'b0, 1'b0, 1'b0, 8'h97);
      edge_();

      // Illegal rd+wr: sticky error, not decoded; later legal write still ticks.
      bus_set(1'b1, 1'b0, 1'b1, 1'b1, 8'h98);
      edge_();
      outs("err", 2'b00, 2'b00, 3'd0, 1'b1);
      bus_set(1'b0, 1'b0, 1'b0, 1'b0, 8'h98);
      edge_();
      bus_set(1'b1, 1'b0, 1'b1, 1'b0, 8'h98);
      edge_();
      outs("err_wr98", 2'b01, 2'b00, 3'd0, 1'b1);
      bus_set(1'b0, 1'b0, 1'b0, 1'b0, 8'h98);
      edge_();
      outs("err_sticky", 2'b00, 2'b00, 3'd0, 1'b1);

      // Reset on the edge that would enter FIRE, then iorq re-decoded fresh.
      bus_set(1'b1, 1'b0, 1'b0, 1'b1, 8'h99);
      edge_();
      edge_();
      outs("rst_e2", 2'b00, 2'b00, 3'd1, 1'b1);
      reset = 1'b1;
      edge_();
      outs("rst_e3", 2'b00, 2'b00, 3'd0, 1'b0);
      reset = 1'b0;
      edge_();
      outs("redec_e1", 2'b00, 2'b00, 3'd1, 1'b0);
      edge_();
      outs("redec_e2", 2'b00, 2'b00, 3'd1, 1'b0);
      edge_();
      outs("redec_e3", 2'b00, 2'b10, 3'd1, 1'b0);
      bus_set(1'b0, 1'b0, 1'b0, 1'b0, 8'h99);
      edge_();
      outs("redec_end", 2'b00, 2'b00, 3'd0, 1'b0);

`ifdef IORQ_CYCLE_WAIT_EN
      // busy high for two edges: wait_n low for two periods, tick when busy seen low.
      bus.busy = 1'b1;
      bus_set(1'b1, 1'b0, 1'b1, 1'b0, 8'h98);
      #1;
      chk("wait_pre", 32'(bus.wait_n), 32'd0);
      edge_();
      chk("wait_e1", 32'(bus.wait_n), 32'd0);
      outs("wait_e1", 2'b00, 2'b00, 3'd0, 1'b0);
      edge_();
      outs("wait_e2", 2'b00, 2'b00, 3'd0, 1'b0);
      bus.busy = 1'b0;
      #1;
      chk("wait_rel", 32'(bus.wait_n), 32'd1);
      edge_();
      outs("wait_fire", 2'b01, 2'b00, 3'd0, 1'b0);
      chk("wait_fire_n", 32'(bus.wait_n), 32'd1);
      bus_set(1'b0, 1'b0, 1'b0, 1'b0, 8'h98);
      edge_();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_iorq_cycle_fsm
`default_nettype wire
